apb_cmd_requester: RTL

- APB requester: converts a simple valid/ready command stream into APB setup/access transfers, and returns read data and status on a response handshake.
- Drives the watchdog's APB completer port, i.e. the other end of the APB signal set (PADDR/PSEL/PENABLE/PWRITE/PWDATA out; PRDATA/PREADY in).
- Used as the synthesizable CPU-side front end for watchdog register programming in subsystem integration.

---
 rtl/wdog_apb_pkg.sv | 27 ++
 rtl/apb_cmd_requester_if.sv | 42 ++++
 rtl/apb_wait_timer.sv | 27 ++
 rtl/apb_cmd_requester.sv | 112 +++++++++++
 4 files changed

// File: rtl/wdog_apb_pkg.sv
// Shared definitions for the watchdog APB command requester: FSM state
// encoding, watchdog register map, unlock key and default timeout.
package wdog_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

  // Watchdog completer register offsets
  localparam logic [11:0] WDOGLOAD    = 12'h000;
  localparam logic [11:0] WDOGVALUE   = 12'h004;
  localparam logic [11:0] WDOGCONTROL = 12'h008;
  localparam logic [11:0] WDOGINTCLR  = 12'h00C;
  localparam logic [11:0] WDOGRIS     = 12'h010;
  localparam logic [11:0] WDOGMIS     = 12'h014;
  localparam logic [11:0] WDOGLOCK    = 12'hC00;

  // Writing this value to WDOGLOCK unlocks the watchdog registers
  localparam logic [31:0] WDOG_UNLOCK_KEY = 32'h1ACC_E551;

  // ACCESS wait cycles tolerated before an abort (timeout build only)
  localparam int DEFAULT_TIMEOUT_CYC = 16;

endpackage

// File: rtl/apb_cmd_requester_if.sv
// Command/response stream plus APB signal set of the requester.
//
// Handshakes: a command transfers on a cycle where CMDVALID && CMDREADY
// at posedge pclk; a response transfers on a cycle where RSPVALID &&
// RSPREADY. Once RSPVALID is high it stays high, with RSPRDATA/RSPERR
// stable, until RSPREADY is seen. APB follows the usual SETUP (PSEL only)
// then ACCESS (PSEL+PENABLE) phases, finishing when PREADY is high.
interface apb_cmd_requester_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              CMDVALID;
  logic              CMDREADY;
  logic              CMDWRITE;
  logic [ADDR_W-1:0] CMDADDR;
  logic [DATA_W-1:0] CMDWDATA;
  logic              RSPVALID;
  logic              RSPREADY;
  logic [DATA_W-1:0] RSPRDATA;
  logic              RSPERR;
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  // Requester side: consumes commands, produces responses, drives APB
  modport master (
    input  CMDVALID, CMDWRITE, CMDADDR, CMDWDATA, RSPREADY, PRDATA, PREADY,
    output CMDREADY, RSPVALID, RSPRDATA, RSPERR,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  // Environment side: command source, response sink and APB completer
  modport slave (
    output CMDVALID, CMDWRITE, CMDADDR, CMDWDATA, RSPREADY, PRDATA, PREADY,
    input  CMDREADY, RSPVALID, RSPRDATA, RSPERR,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent with PREADY low and flags the cycle on which
// the limit is reached while the completer is still not ready.
module apb_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,    // high in SETUP: counter cleared for the coming ACCESS
  input  logic waiting,  // high on an ACCESS cycle with PREADY low
  output logic hit
);
  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt;

  // hit marks the LIMIT-th waiting cycle; PREADY high on that cycle wins
  assign hit = waiting && (cnt == LAST);

  // Wait counter: clear before ACCESS, count each not-ready ACCESS cycle
  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt <= 8'd0;
    end else if (waiting && !hit) begin
      cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: rtl/apb_cmd_requester.sv
// APB requester: turns a valid/ready command stream into one APB
// SETUP/ACCESS transfer at a time and returns read data and status on a
// valid/ready response stream.
// Optional build macro APB_TIMEOUT_EN: aborts an ACCESS phase after
// TIMEOUT_CYC not-ready cycles and reports RSPERR=1. Without it ACCESS
// waits indefinitely and RSPERR stays 0.
module apb_cmd_requester
  import wdog_apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                pclk,
  input  logic                PRESET,
  apb_cmd_requester_if.master bus,
  output apb_state_t          state
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..255");
  end

  apb_state_t state_next;
  logic       accept;
  logic       timeout_hit;

  assign accept = (state == ST_IDLE) && bus.CMDVALID;

`ifdef APB_TIMEOUT_EN
  apb_wait_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk     (pclk),
    .rst     (PRESET),
    .start   (state == ST_SETUP),
    .waiting ((state == ST_ACCESS) && !bus.PREADY),
    .hit     (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge pclk) begin
    if (PRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_next   = state;
    bus.CMDREADY = 1'b0;
    bus.PSEL     = 1'b0;
    bus.PENABLE  = 1'b0;
    bus.RSPVALID = 1'b0;
    case (state)
      ST_IDLE: begin
        // Held low during reset so nothing looks accepted
        bus.CMDREADY = !PRESET;
        if (bus.CMDVALID) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        bus.PSEL   = 1'b1;
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
        if (bus.PREADY || timeout_hit) state_next = ST_RESP;
      end
      ST_RESP: begin
        bus.RSPVALID = 1'b1;
        if (bus.RSPREADY) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Address/direction/write data: latched on accept, held until next accept
  always_ff @(posedge pclk) begin
    if (PRESET) begin
      bus.PADDR  <= {ADDR_W{1'b0}};
      bus.PWRITE <= 1'b0;
      bus.PWDATA <= {DATA_W{1'b0}};
    end else if (accept) begin
      bus.PADDR  <= bus.CMDADDR;
      bus.PWRITE <= bus.CMDWRITE;
      bus.PWDATA <= bus.CMDWDATA;
    end
  end

  // Response payload: captured when ACCESS ends, stable through RESP
  always_ff @(posedge pclk) begin
    if (PRESET) begin
      bus.RSPRDATA <= {DATA_W{1'b0}};
      bus.RSPERR   <= 1'b0;
    end else if (state == ST_ACCESS) begin
      if (bus.PREADY) begin
        bus.RSPRDATA <= bus.PWRITE ? {DATA_W{1'b0}} : bus.PRDATA;
        bus.RSPERR   <= 1'b0;
      end else if (timeout_hit) begin
        bus.RSPRDATA <= {DATA_W{1'b0}};
        bus.RSPERR   <= 1'b1;
      end
    end
  end

endmodule
